// File: rtl/riscv16_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer that owns PC and IR for the 16-bit core.
// Latency 2-5 cycles per instruction plus memory wait; MEM holds MEM_REQ high until MEM_READY (no timeout).
module riscv16_ctrl_fsm #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_WORD = 16'hD000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] INSTR,
   output logic [15:0] PC,
   input  logic        FLAG,
   output logic [2:0]  ALU_CTRL,
   output logic        B_SEL,
   output logic [15:0] IMM,
   output logic [2:0]  RF_RA1,
   output logic [2:0]  RF_RA2,
   output logic [2:0]  RF_WA,
   output logic        RF_WE,
   output logic        WB_SEL,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   input  logic        MEM_READY,
   output logic        HALTED,
   output logic        ILLEGAL
);
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
   } state_t;

   localparam logic [3:0] OP_ADDI = 4'd8;
   localparam logic [3:0] OP_LD   = 4'd9;
   localparam logic [3:0] OP_ST   = 4'd10;
   localparam logic [3:0] OP_BEQ  = 4'd11;
   localparam logic [3:0] OP_JMP  = 4'd12;
   localparam logic [3:0] OP_NOP  = 4'd13;
   localparam logic [3:0] OP_ILL  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt;
   logic [15:0] r_ir, w_ir_nxt;
   logic        r_illegal, w_illegal_nxt;

   logic [3:0]  w_op;
   logic [2:0]  w_rd, w_rs1, w_rs2;

   assign w_op  = r_ir[15:12];
   assign w_rd  = r_ir[11:9];
   assign w_rs1 = r_ir[8:6];
   assign w_rs2 = r_ir[5:3];

   // Decode fields follow IR directly, so they stay stable until the next FETCH reloads it.
   assign IMM      = {{10{r_ir[5]}}, r_ir[5:0]};
   assign RF_RA1   = (w_op == OP_BEQ) ? w_rd : w_rs1;
   assign RF_RA2   = (w_op == OP_ST) ? w_rd : ((w_op == OP_BEQ) ? w_rs1 : w_rs2);
   assign RF_WA    = w_rd;
   assign ALU_CTRL = !w_op[3] ? w_op[2:0] : ((w_op == OP_BEQ) ? 3'd1 : 3'd0);
   assign B_SEL    = (w_op == OP_ADDI) || (w_op == OP_LD) || (w_op == OP_ST);
   assign WB_SEL   = (w_op == OP_LD);
   assign PC       = r_pc;
   assign ILLEGAL  = r_illegal;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_PC;
         r_ir      <= NOP_WORD;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_ir      <= w_ir_nxt;
         r_illegal <= w_illegal_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_ir_nxt      = r_ir;
      w_illegal_nxt = r_illegal;
      RF_WE         = 1'b0;
      MEM_REQ       = 1'b0;
      MEM_WE        = 1'b0;
      HALTED        = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_nxt    = INSTR;
            w_pc_nxt    = r_pc + 16'd1;
            w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            case (w_op)
               OP_JMP: begin
                  w_pc_nxt    = {4'h0, r_ir[11:0]};
                  w_state_nxt = S_FETCH;
               end
               OP_NOP:  w_state_nxt = S_FETCH;
               OP_ILL: begin
                  w_illegal_nxt = 1'b1;
                  w_state_nxt   = S_FETCH;
               end
               OP_HALT: w_state_nxt = S_HALT;
               default: w_state_nxt = S_EXECUTE;
            endcase
         end
         S_EXECUTE: begin
            if ((w_op == OP_LD) || (w_op == OP_ST)) begin
               w_state_nxt = S_MEM;
            end else if (w_op == OP_BEQ) begin
               // PC already points past the branch, so the offset is relative to PC+1.
               if (FLAG) w_pc_nxt = r_pc + IMM;
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_WRITEBACK;
            end
         end
         S_MEM: begin
            MEM_REQ = 1'b1;
            MEM_WE  = (w_op == OP_ST);
            if (MEM_READY) w_state_nxt = (w_op == OP_LD) ? S_WRITEBACK : S_FETCH;
         end
         S_WRITEBACK: begin
            RF_WE       = 1'b1;
            w_state_nxt = S_FETCH;
         end
         S_HALT:  HALTED = 1'b1;
         default: w_state_nxt = S_FETCH;
      endcase
   end
endmodule

// File: doc/riscv16_ctrl_fsm.md
Name: riscv16_ctrl_fsm

Overview:
- Multi-cycle control unit for the 16-bit RISC core. Drives the ALU, register file, data memory and PC.
- Owns the PC and instruction register (IR).
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Generates ALU_CTRL, operand-select, register-file and memory-handshake controls. Consumes the ALU zero FLAG for branches.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_WORD, 16'hD000, IR value loaded on reset.

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- INSTR  in  16  instruction memory read data for address PC (combinational read)
- PC  out  16  program counter / instruction memory address
- FLAG  in  1  ALU zero flag (ALU_OUT==0)
- ALU_CTRL  out  3  ALU op: 0 add, 1 sub, 2 not, 3 shl, 4 shr, 5 and, 6 or, 7 unsigned gt
- B_SEL  out  1  0: ALU B = RF read port 2; 1: ALU B = IMM
- IMM  out  16  sign-extended IR[5:0]
- RF_RA1  out  3  register file read address 1
- RF_RA2  out  3  register file read address 2
- RF_WA  out  3  register file write address
- RF_WE  out  1  register file write enable, one-cycle pulse
- WB_SEL  out  1  0: write back ALU_OUT; 1: write back memory read data
- MEM_REQ  out  1  data memory request; address = ALU_OUT, write data = RF port 2
- MEM_WE  out  1  write qualifier, valid while MEM_REQ=1
- MEM_READY  in  1  memory completes the request in the cycle it is sampled high with MEM_REQ
- HALTED  out  1  core stopped
- ILLEGAL  out  1  sticky: illegal opcode seen

Behaviour:
- Instruction format:
  - op = IR[15:12], rd = IR[11:9], rs1 = IR[8:6], rs2 = IR[5:3], imm6 = IR[5:0], imm12 = IR[11:0].
- Opcodes:
  - 0-7: R-type. ALU_CTRL = op[2:0]; rd = rs1 op rs2.
  - 8: ADDI. rd = rs1 + sext(imm6).
  - 9: LD. rd = mem[rs1 + sext(imm6)].
  - 10: ST. mem[rs1 + sext(imm6)] = R[rd].
  - 11: BEQ. If R[rd] == R[rs1], PC = PC + sext(imm6).
  - 12: JMP. PC = {4'b0, imm12}.
  - 13: NOP.
  - 14: illegal.
  - 15: HALT.
- Decode outputs are combinational from IR, valid from DECODE until the next IR load:
  - RF_RA1 = rs1 (rd for BEQ).
  - RF_RA2 = rs2 (rd for ST, rs1 for BEQ).
  - RF_WA = rd.
  - ALU_CTRL = op[2:0] for op < 8, 1 for BEQ, otherwise 0.
  - B_SEL = 1 for ADDI/LD/ST.
  - WB_SEL = 1 for LD.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH (1 cycle): IR <= INSTR; PC <= PC+1 (16-bit wrap, FFFF -> 0000); -> DECODE.
- DECODE:
  - JMP: PC <= imm12; -> FETCH.
  - NOP: -> FETCH.
  - op 14: ILLEGAL <= 1; -> FETCH (acts as NOP).
  - HALT: -> HALT.
  - All other opcodes: -> EXECUTE.
- EXECUTE:
  - R-type/ADDI: -> WRITEBACK.
  - LD/ST: -> MEM.
  - BEQ: if FLAG, PC <= PC + IMM (PC already incremented, wrap mod 2^16); -> FETCH.
- MEM:
  - MEM_REQ = 1; MEM_WE = 1 for ST.
  - Holds while MEM_READY = 0; no timeout.
  - On MEM_READY = 1: LD -> WRITEBACK; ST -> FETCH.
  - MEM_REQ and MEM_WE are low in all other states.
- WRITEBACK: RF_WE = 1 for exactly this cycle; -> FETCH.
- HALT: HALTED = 1; PC and IR frozen; no requests; exit only via RST.
- Latency in cycles:
  - R-type/ADDI: 4.
  - LD: 5 + memory wait.
  - ST: 4 + wait.
  - BEQ: 3.
  - JMP/NOP/illegal: 2.
- Operands stay stable through MEM and WRITEBACK because IR is not reloaded until FETCH.
- Reset values:
  - State = FETCH, PC = RESET_PC, IR = NOP_WORD.
  - RF_WE = 0, MEM_REQ = 0, MEM_WE = 0, HALTED = 0, ILLEGAL = 0.
  - Derived outputs: ALU_CTRL = 0, B_SEL = 0, WB_SEL = 0.
- Reset has priority over every state, including MEM with MEM_REQ asserted: the request is abandoned and MEM_REQ is low the cycle after RST is sampled.

Test Plan:
- Reset: RST high 2 cycles, RESET_PC = 0 -> PC = 0, HALTED = 0, MEM_REQ = 0, RF_WE = 0. First FETCH loads INSTR and sets PC = 1.
- R-type: INSTR = 16'h0298 (ADD r1, r2, r3) -> ALU_CTRL = 0, RF_RA1 = 2, RF_RA2 = 3; RF_WE = 1, RF_WA = 1 in cycle 4 only; PC = 1.
- ADDI with negative immediate: INSTR = 16'h827F (ADDI r1, r1, -1) -> IMM = 16'hFFFF, B_SEL = 1, ALU_CTRL = 0, RF_WE in WRITEBACK.
- BEQ taken: PC = 5, INSTR = 16'hB27E (imm = -2), FLAG = 1 in EXECUTE -> next PC = 4.
  - Same instruction with FLAG = 0 -> PC = 6.
- LD with memory wait: INSTR = 16'h9281, MEM_READY low 3 cycles then high -> MEM_REQ high 4 cycles, MEM_WE = 0, then WB_SEL = 1 and RF_WE pulse.
  - ST, same stimulus -> MEM_WE = 1, no RF_WE.
- Illegal and HALT:
  - INSTR = 16'hE000 -> ILLEGAL = 1 (sticky), PC advances.
  - INSTR = 16'hF000 -> HALTED = 1, PC constant for 10 cycles.
  - RST asserted mid-MEM -> MEM_REQ = 0 the next cycle, PC = RESET_PC.
